fpio_tx_sched: RTL and testbench
================================

# fpio_tx_sched

Round-robin frame scheduler that shares one fpio transmitter between NUM_REQ requesters. A requester is granted for a whole frame, from its first beat through the beat flagged last, and is never pre-empted mid-frame. The block also loads the transmitter's bit-rate divisor with the granted requester's value, and changes it only while the transmitter is idle. It sits directly upstream of the fpio transmit datapath and owns its divisor input.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 4: beat width, matching the transmitter.
- GAP_CYCLES, 2: idle clocks inserted after each frame, 0..255.

Ports:
- clk, input, 1: sole clock.
- rstn, input, 1: reset, asynchronous, active-low.
- req_valid, input, NUM_REQ: per-requester beat valid.
- req_ready, output, NUM_REQ: per-requester beat accepted.
- req_data, input, NUM_REQ*DATA_WIDTH: beat data, requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last, input, NUM_REQ: final beat of frame.
- req_divisor, input, NUM_REQ*32: per-requester divisor, requester i in bits [i*32 +: 32].
- tx_valid, output, 1: beat to transmitter.
- tx_ready, input, 1: transmitter accepts beat.
- tx_data, output, DATA_WIDTH: beat data.
- tx_last, output, 1: final beat.
- tx_busy, input, 1: transmitter still shifting; divisor must not change.
- divisor, output, 32: registered divisor to transmitter.
- grant_id, output, $clog2(NUM_REQ): current or most recent grantee.
- busy, output, 1: high in XFER or GAP.

## Operation
- States:
  - IDLE: no requester granted.
  - XFER: one requester owns the transmitter.
  - GAP: mandatory spacing after a frame.
- IDLE→XFER happens when any req_valid is high and tx_busy is low. Winner is the first set req_valid scanning from (last_grant+1) mod NUM_REQ upward with wrap. On that edge, grant_id ← winner, last_grant ← winner, divisor ← req_divisor[winner].
- If tx_busy is high, the block stays in IDLE regardless of requests.
- XFER datapath is combinational from the grantee:
  - tx_valid = req_valid[g].
  - tx_data = req_data[g].
  - tx_last = req_last[g].
  - req_ready[g] = tx_ready.
  - All other req_ready bits are 0.
- XFER→GAP happens on a transfer (tx_valid && tx_ready) with tx_last=1, when GAP_CYCLES>0. When GAP_CYCLES=0 the state goes to IDLE instead.
- GAP: an 8-bit counter loads GAP_CYCLES-1 on entry and decrements each clock. GAP→IDLE happens when the counter reaches 0. tx_valid=0 and all req_ready=0 throughout.
- Outside XFER: tx_valid=0, tx_last=0, req_ready=0, tx_data=0.
- If the grantee drops req_valid mid-frame, the grant is held; tx_valid follows req_valid[g]. There is no timeout.
- req_divisor changes after grant are ignored until the next grant.
- The round-robin pointer updates only on grant. A requester that raised req_valid late in a cycle loses nothing; it is evaluated on the next IDLE cycle.

## Timing
- Reset values (asynchronous):
  - state = IDLE, last_grant = NUM_REQ-1 (requester 0 has first priority), grant_id = 0, divisor = 0, gap counter = 0.
  - busy = 0, tx_valid = 0, tx_last = 0, tx_data = 0, req_ready = 0.
- Grant latency is 1 clock. A request seen in IDLE at edge t puts the first beat on tx at cycle t+1, and that beat can transfer in cycle t+1.
- Frame-to-frame spacing is the last-beat transfer edge, then GAP_CYCLES clocks in GAP, then 1 IDLE arbitration clock.
- divisor is stable from a grant edge until the next grant edge. It never changes while tx_busy=1 or while in XFER/GAP.
- A single-beat frame (req_last=1 on the first beat) is legal: XFER lasts 1 clock when tx_ready=1.
- Reset asserted mid-frame returns the block to IDLE immediately and drops all outputs to their reset values. The partial frame is abandoned, and the requester must restart it.

## Test plan
- Requester 0 alone, frame of 3 beats (data 0x1, 0x2, 0x3), req_divisor0 = 0x10, tx_ready tied 1, GAP_CYCLES = 2 → divisor = 0x10 one clock after request. Beats appear on consecutive cycles with tx_last on 0x3. busy falls 3 clocks after the last beat.
- All 4 requesters continuously valid with 1-beat frames → grant_id sequence 0, 1, 2, 3, 0. No requester receives req_ready outside its grant.
- Requester 2 mid-frame with tx_ready low for 5 cycles while requester 1 asserts valid → no switch. Requester 1 is granted only after requester 2's last beat plus the gap.
- tx_busy = 1 for 10 cycles with requester 3 pending → state stays IDLE and divisor is unchanged. Grant occurs on the first clock after tx_busy falls.
- req_divisor1 changed from 0x20 to 0x40 during requester 1's frame → divisor stays 0x20 until the next grant.
- rstn pulsed low during beat 2 of a 4-beat frame → all outputs return to reset values immediately. After release, requester 0 has priority and GAP_CYCLES = 0 paths go XFER→IDLE directly.

Source files
------------

// File: rtl/fpio_tx_sched.sv
// Round-robin frame scheduler sharing one fpio transmitter between
// NUM_REQ requesters; owns the transmitter divisor.
//
// Ports:
//   clk, rstn                     clock, async active-low reset
//   req_valid/ready/data/last     per-requester beat stream
//   req_divisor                   per-requester 32-bit divisor
//   tx_valid/ready/data/last      beat stream to transmitter
//   tx_busy                       transmitter still shifting
//   divisor                       registered divisor to transmitter
//   grant_id                      current or most recent grantee
//   busy                          high while in XFER or GAP
module fpio_tx_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int GAP_CYCLES = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*32-1:0]         req_divisor,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_last,
  input  logic                          tx_busy,
  output logic [31:0]                   divisor,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int GAP_M1 =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [31:0]   div_q, div_d;
  logic [7:0]    gap_q, gap_d;

  logic          win_found;
  logic [IW-1:0] win_id;
  logic          fire;

  // Scan starts one past the previous grantee and wraps.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = int'(last_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_id    = IW'(j);
      end
    end
  end

  assign fire = req_valid[grant_q] && tx_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    div_d   = div_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        // Divisor may only move while the shifter is quiet.
        if (win_found && !tx_busy) begin
          state_d = S_XFER;
          grant_d = win_id;
          last_d  = win_id;
          div_d   = req_divisor[int'(win_id)*32 +: 32];
        end
      end
      S_XFER: begin
        if (fire && req_last[grant_q]) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = 8'(GAP_M1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      div_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
    end
  end

  // Grantee's stream passes straight through while in XFER.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_last   = 1'b0;
    req_ready = '0;
    if (state_q == S_XFER) begin
      tx_valid = req_valid[grant_q];
      tx_data  =
        req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      tx_last  = req_last[grant_q];
      req_ready[grant_q] = tx_ready;
    end
  end

  assign divisor  = div_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpio_tx_sched.sv
// Directed bench for fpio_tx_sched with a beat scoreboard.
// Second instance covers the zero-gap configuration.
module tb_fpio_tx_sched;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_data;
  logic [3:0]   req_last;
  logic [127:0] req_divisor;
  logic         tx_valid;
  logic         tx_ready;
  logic [3:0]   tx_data;
  logic         tx_last;
  logic         tx_busy;
  logic [31:0]  divisor;
  logic [1:0]   grant_id;
  logic         busy;

  logic [1:0]   b_req_valid;
  logic [1:0]   b_req_ready;
  logic [7:0]   b_req_data;
  logic [1:0]   b_req_last;
  logic [63:0]  b_req_divisor;
  logic         b_tx_valid;
  logic         b_tx_ready;
  logic [3:0]   b_tx_data;
  logic         b_tx_last;
  logic         b_tx_busy;
  logic [31:0]  b_divisor;
  logic [0:0]   b_grant_id;
  logic         b_busy;

  fpio_tx_sched #(
    .NUM_REQ(4), .DATA_WIDTH(4), .GAP_CYCLES(2)
  ) u0 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_last(req_last),
    .req_divisor(req_divisor),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last),
    .tx_busy(tx_busy), .divisor(divisor),
    .grant_id(grant_id), .busy(busy)
  );

  fpio_tx_sched #(
    .NUM_REQ(2), .DATA_WIDTH(4), .GAP_CYCLES(0)
  ) u1 (
    .clk(clk), .rstn(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_data(b_req_data), .req_last(b_req_last),
    .req_divisor(b_req_divisor),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_data(b_tx_data), .tx_last(b_tx_last),
    .tx_busy(b_tx_busy), .divisor(b_divisor),
    .grant_id(b_grant_id), .busy(b_busy)
  );

  typedef struct {
    int         id;
    logic [3:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int vecs = 0;
  int errs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [3:0] d,
                      input logic l);
    beat_t e;
    e.id = id; e.data = d; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic drv(input int i, input logic v,
                     input logic [3:0] d, input logic l);
    req_valid[i]     = v;
    req_data[i*4+:4] = d;
    req_last[i]      = l;
  endtask

  // Sample mid-cycle, then advance to just past the next edge.
  task automatic cyc();
    beat_t e;
    logic [3:0] oh;
    @(negedge clk);
    chk("rdy_onehot", 128'($countones(req_ready) <= 1), 1);
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", {tx_data, tx_last}, 0);
        chk("sb_unexpected_vld", tx_valid, 0);
      end else begin
        e = exp_q.pop_front();
        oh = 4'b0001 << e.id;
        chk("beat_id", grant_id, e.id);
        chk("beat_data", tx_data, e.data);
        chk("beat_last", tx_last, e.last);
        chk("beat_rdy", req_ready, oh);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc();
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      cyc();
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    req_divisor = '0; tx_ready = 1'b1; tx_busy = 1'b0;
    b_req_valid = '0; b_req_data = '0; b_req_last = '0;
    b_req_divisor = '0; b_tx_ready = 1'b1; b_tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_div", divisor, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_b_div", b_divisor, 0);
    rstn = 1'b1;

    // Requester 0 alone, three-beat frame.
    req_divisor[0*32+:32] = 32'h10;
    drv(0, 1, 4'h1, 0);
    push(0, 4'h1, 0);
    cyc();
    chk("t1_div", divisor, 32'h10);
    chk("t1_busy", busy, 1);
    cyc();
    drv(0, 1, 4'h2, 0);
    push(0, 4'h2, 0);
    cyc();
    drv(0, 1, 4'h3, 1);
    push(0, 4'h3, 1);
    cyc();
    drv(0, 0, 4'h0, 0);
    chk("t1_gap0", busy, 1);
    cyc();
    chk("t1_gap1", busy, 1);
    cyc();
    chk("t1_idle", busy, 0);
    chk("t1_sb", exp_q.size(), 0);

    // All four requesters, single-beat frames.
    do_reset();
    for (int i = 0; i < 4; i++) drv(i, 1, 4'(4 + i), 1);
    for (int i = 0; i < 4; i++) push(i, 4'(4 + i), 1);
    push(0, 4'h4, 1);
    drain(40);
    req_valid = '0;
    wait_idle();

    // Requester 2 held mid-frame, requester 1 waiting.
    req_divisor[2*32+:32] = 32'h50;
    req_divisor[1*32+:32] = 32'h20;
    drv(2, 1, 4'hA, 0);
    push(2, 4'hA, 0);
    cyc();
    chk("t3_gid2", grant_id, 2);
    tx_ready = 1'b0;
    drv(1, 1, 4'hB, 1);
    repeat (5) cyc();
    chk("t3_hold", grant_id, 2);
    chk("t3_div", divisor, 32'h50);
    tx_ready = 1'b1;
    cyc();
    drv(2, 1, 4'hC, 1);
    push(2, 4'hC, 1);
    cyc();
    drv(2, 0, 4'h0, 0);
    push(1, 4'hB, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("t3_spacing", n, 4);
    drv(1, 0, 4'h0, 0);
    chk("t3_div1", divisor, 32'h20);
    wait_idle();

    // Transmitter busy blocks arbitration.
    req_divisor[3*32+:32] = 32'h33;
    tx_busy = 1'b1;
    drv(3, 1, 4'hD, 1);
    push(3, 4'hD, 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_idle", busy, 0);
      chk("t4_div", divisor, 32'h20);
    end
    tx_busy = 1'b0;
    cyc();
    chk("t4_gid", grant_id, 3);
    chk("t4_div3", divisor, 32'h33);
    cyc();
    drv(3, 0, 4'h0, 0);
    wait_idle();

    // Divisor change mid-frame is ignored.
    req_divisor[1*32+:32] = 32'h20;
    drv(1, 1, 4'h1, 0);
    push(1, 4'h1, 0);
    cyc();
    chk("t5_div_a", divisor, 32'h20);
    req_divisor[1*32+:32] = 32'h40;
    cyc();
    drv(1, 1, 4'h2, 1);
    push(1, 4'h2, 1);
    chk("t5_div_b", divisor, 32'h20);
    cyc();
    drv(1, 0, 4'h0, 0);
    chk("t5_div_c", divisor, 32'h20);
    wait_idle();
    chk("t5_div_d", divisor, 32'h20);
    drv(1, 1, 4'h3, 1);
    push(1, 4'h3, 1);
    cyc();
    chk("t5_div_new", divisor, 32'h40);
    cyc();
    drv(1, 0, 4'h0, 0);
    wait_idle();

    // Reset during beat 2 of a four-beat frame.
    drv(0, 1, 4'h1, 0);
    push(0, 4'h1, 0);
    cyc();
    cyc();
    drv(0, 1, 4'h2, 0);
    #1;
    chk("t6_pre_txv", tx_valid, 1);
    rstn = 1'b0;
    #1;
    chk("t6_txv", tx_valid, 0);
    chk("t6_txd", tx_data, 0);
    chk("t6_txl", tx_last, 0);
    chk("t6_rdy", req_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_div", divisor, 0);
    chk("t6_gid", grant_id, 0);
    rstn = 1'b1;
    drv(0, 1, 4'h5, 1);
    drv(3, 1, 4'h7, 1);
    push(0, 4'h5, 1);
    push(3, 4'h7, 1);
    drain(20);
    req_valid = '0;
    wait_idle();

    // Zero-gap instance: XFER returns straight to IDLE.
    b_req_valid = 2'b11;
    b_req_last = 2'b11;
    b_req_data = {4'h9, 4'h6};
    b_req_divisor = {32'h22, 32'h11};
    cyc();
    chk("g0_busy_a", b_busy, 1);
    chk("g0_gid_a", b_grant_id, 0);
    chk("g0_txd_a", b_tx_data, 4'h6);
    chk("g0_rdy_a", b_req_ready, 2'b01);
    chk("g0_div_a", b_divisor, 32'h11);
    cyc();
    chk("g0_idle_a", b_busy, 0);
    chk("g0_txv_a", b_tx_valid, 0);
    cyc();
    chk("g0_gid_b", b_grant_id, 1);
    chk("g0_txd_b", b_tx_data, 4'h9);
    chk("g0_rdy_b", b_req_ready, 2'b10);
    chk("g0_div_b", b_divisor, 32'h22);
    cyc();
    chk("g0_idle_b", b_busy, 0);
    b_req_valid = '0;

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
